// File: rtl/datapath_pkg.sv
// Shared types for the handshaked ALU pipeline: opcode encoding and the result flag bundle.
package datapath_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } opcode_e;

    typedef struct packed {
        logic co;
        logic ov;
        logic zero;
    } flags_t;

    localparam flags_t FlagsRst = '{co: 1'b0, ov: 1'b0, zero: 1'b1};

endpackage

// File: rtl/datapath_pipe_hs_if.sv
// Valid/ready operand and result channels of the ALU pipeline.
interface datapath_pipe_hs_if #(
    parameter int unsigned N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Y;
    logic         co;
    logic         ov;
    logic         zero;

    modport master (
        output in_valid, A, B, opcode, out_ready,
        input  in_ready, out_valid, Y, co, ov, zero
    );

    modport slave (
        input  in_valid, A, B, opcode, out_ready,
        output in_ready, out_valid, Y, co, ov, zero
    );
endinterface

// File: rtl/datapath_alu.sv
// Combinational signed ALU: add/sub with optional saturation, logic ops and 1-bit shifts.
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int unsigned N   = 16,
    parameter bit          SAT = 1'b0
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  opcode_e      op_i,
    output logic [N-1:0] y_o,
    output flags_t       flags_o
);

    localparam logic [N-1:0] MaxPos = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MinNeg = {1'b1, {(N-1){1'b0}}};

    logic         sub;
    logic [N:0]   sum;

    // Subtraction is A + ~B + 1 so co reads as "no borrow".
    always_comb begin
        sub = (op_i == OP_SUB);
        sum = {1'b0, a_i} + {1'b0, (sub ? ~b_i : b_i)} + {{N{1'b0}}, sub};
    end

    always_comb begin
        y_o     = '0;
        flags_o = '0;
        unique case (op_i)
            OP_ADD, OP_SUB: begin
                y_o        = sum[N-1:0];
                flags_o.co = sum[N];
                flags_o.ov = (a_i[N-1] == (b_i[N-1] ^ sub)) && (sum[N-1] != a_i[N-1]);
                // Overflow direction always follows the sign of A.
                if (SAT && flags_o.ov) begin
                    y_o = a_i[N-1] ? MinNeg : MaxPos;
                end
            end
            OP_AND: y_o = a_i & b_i;
            OP_OR:  y_o = a_i | b_i;
            OP_XOR: y_o = a_i ^ b_i;
            OP_NOT: y_o = ~a_i;
            OP_SHL: begin
                y_o        = {a_i[N-2:0], 1'b0};
                flags_o.co = a_i[N-1];
                flags_o.ov = a_i[N-1] ^ a_i[N-2];
            end
            OP_SHR: begin
                y_o        = {a_i[N-1], a_i[N-1:1]};
                flags_o.co = a_i[0];
            end
            default: y_o = '0;
        endcase
        flags_o.zero = (y_o == '0);
    end

endmodule

// File: rtl/datapath_pipe_hs.sv
// ALU followed by STAGES valid/ready register slices; STAGES=0 gives a purely combinational path.
module datapath_pipe_hs
    import datapath_pkg::*;
#(
    parameter int unsigned N      = 16,
    parameter int unsigned STAGES = 2,
    parameter bit          SAT    = 1'b0
) (
    input logic               clk,
    input logic               rst,
    datapath_pipe_hs_if.slave bus
);

    logic [N-1:0] alu_y;
    flags_t       alu_flags;

    datapath_alu #(
        .N   (N),
        .SAT (SAT)
    ) u_alu (
        .a_i     (bus.A),
        .b_i     (bus.B),
        .op_i    (opcode_e'(bus.opcode)),
        .y_o     (alu_y),
        .flags_o (alu_flags)
    );

    if (STAGES == 0) begin : g_comb
        assign bus.in_ready  = bus.out_ready;
        assign bus.out_valid = bus.in_valid;
        assign bus.Y         = alu_y;
        assign bus.co        = alu_flags.co;
        assign bus.ov        = alu_flags.ov;
        assign bus.zero      = alu_flags.zero;
    end else begin : g_pipe
        // Index 0 is the ALU output; index g+1 is the register of stage g.
        logic   [STAGES:0]        v_c;
        logic   [STAGES:0][N-1:0] y_c;
        flags_t [STAGES:0]        f_c;
        logic   [STAGES-1:0]      adv;

        assign v_c[0] = bus.in_valid;
        assign y_c[0] = alu_y;
        assign f_c[0] = alu_flags;

        for (genvar g = 0; g < STAGES; g++) begin : g_stage
            logic         valid_q, valid_d;
            logic [N-1:0] y_q, y_d;
            flags_t       flags_q, flags_d;

            // A stage moves when any slot from here to the output is empty or the sink is ready.
            assign adv[g] = bus.out_ready || !(&v_c[STAGES:g+1]);

            always_comb begin
                valid_d = valid_q;
                y_d     = y_q;
                flags_d = flags_q;
                if (adv[g]) begin
                    valid_d = v_c[g];
                    if (v_c[g]) begin
                        y_d     = y_c[g];
                        flags_d = f_c[g];
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    y_q     <= '0;
                    flags_q <= FlagsRst;
                end else begin
                    valid_q <= valid_d;
                    y_q     <= y_d;
                    flags_q <= flags_d;
                end
            end

            assign v_c[g+1] = valid_q;
            assign y_c[g+1] = y_q;
            assign f_c[g+1] = flags_q;
        end

        assign bus.in_ready  = adv[0];
        assign bus.out_valid = v_c[STAGES];
        assign bus.Y         = y_c[STAGES];
        assign bus.co        = f_c[STAGES].co;
        assign bus.ov        = f_c[STAGES].ov;
        assign bus.zero      = f_c[STAGES].zero;
    end

endmodule

// File: tb/tb_datapath_pipe_hs.sv
// Directed scoreboard bench: 2-stage pipe (SAT=0), 2-stage pipe (SAT=1) and a STAGES=0 instance.
module tb_datapath_pipe_hs;
    import datapath_pkg::*;

    localparam int unsigned N = 16;

    typedef struct packed {
        logic [15:0] y;
        logic        co;
        logic        ov;
        logic        zero;
    } res_t;

    typedef struct {
        res_t r;
        int   cyc;
        bit   lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    datapath_pipe_hs_if #(.N(N)) bm ();
    datapath_pipe_hs_if #(.N(N)) bs ();
    datapath_pipe_hs_if #(.N(N)) bc ();

    datapath_pipe_hs #(.N(N), .STAGES(2), .SAT(1'b0)) dut      (.clk(clk), .rst(rst), .bus(bm));
    datapath_pipe_hs #(.N(N), .STAGES(2), .SAT(1'b1)) dut_sat  (.clk(clk), .rst(rst), .bus(bs));
    datapath_pipe_hs #(.N(N), .STAGES(0), .SAT(1'b0)) dut_comb (.clk(clk), .rst(rst), .bus(bc));

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   lat_chk  = 1'b0;
    exp_t sb[$];
    exp_t e;
    res_t held;
    bit   stalled  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input bit sat);
        int          sa, sb_, s;
        logic [15:0] y;
        logic        co, ov;
        sa = int'($signed(a));
        sb_ = int'($signed(b));
        co = 1'b0;
        ov = 1'b0;
        y  = '0;
        case (op)
            3'd0, 3'd1: begin
                if (op == 3'd0) begin
                    s  = sa + sb_;
                    co = (int'(a) + int'(b)) > 65535;
                end else begin
                    s  = sa - sb_;
                    co = (a >= b);
                end
                y  = s[15:0];
                ov = (s > 32767) || (s < -32768);
                if (sat && ov) y = (s > 0) ? 16'h7FFF : 16'h8000;
            end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = ~a;
            3'd6: begin
                y  = a + a;
                co = a[15];
                ov = (sa > 16383) || (sa < -16384);
            end
            default: begin
                y  = 16'(sa >>> 1);
                co = a[0];
            end
        endcase
        return '{y: y, co: co, ov: ov, zero: (y == 16'h0)};
    endfunction

    // Scoreboard consumer and output-hold checker for the main instance.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_hold", {13'd0, bm.out_valid, bm.Y, bm.co, bm.ov, bm.zero},
                    {13'd0, 1'b1, held});
            end
            if (bm.out_valid && bm.out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", {31'd0, bm.out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result", {13'd0, bm.Y, bm.co, bm.ov, bm.zero}, {13'd0, e.r});
                    if (e.lat) chk("latency", cyc, e.cyc + 2);
                end
            end
            stalled = bm.out_valid && !bm.out_ready;
            held    = '{y: bm.Y, co: bm.co, ov: bm.ov, zero: bm.zero};
        end
    end

    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        bit done = 1'b0;
        bm.in_valid = 1'b1;
        bm.opcode   = op;
        bm.A        = a;
        bm.B        = b;
        while (!done) begin
            @(negedge clk);
            if (bm.in_ready) begin
                sb.push_back('{r: model(op, a, b, 1'b0), cyc: cyc, lat: lat_chk});
                done = 1'b1;
            end else if (++n > 50) begin
                chk("in_ready_timeout", {31'd0, bm.in_ready}, 32'd1);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bm.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic sat_case(input string tag, input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] ey, input logic eco);
        bs.in_valid = 1'b1;
        bs.opcode   = op;
        bs.A        = a;
        bs.B        = b;
        @(posedge clk);
        #1;
        bs.in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, {31'd0, bs.out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, bs.out_valid}, 32'd1);
        chk({tag, "_y_co_ov"}, {14'd0, bs.Y, bs.co, bs.ov}, {14'd0, ey, eco, 1'b1});
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  t_op [8] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    logic [15:0] t_a  [8] = '{16'hF0F0, 16'h1234, 16'hAAAA, 16'h00FF, 16'h4000, 16'h8001,
                              16'hFFFF, 16'h8000};
    logic [15:0] t_b  [8] = '{16'h0FF0, 16'h00FF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
                              16'h0001, 16'h0001};

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        res_t        r;
        rst = 1'b1;
        bm.in_valid = 1'b0; bm.out_ready = 1'b1; bm.A = '0; bm.B = '0; bm.opcode = '0;
        bs.in_valid = 1'b0; bs.out_ready = 1'b1; bs.A = '0; bs.B = '0; bs.opcode = '0;
        bc.in_valid = 1'b0; bc.out_ready = 1'b1; bc.A = '0; bc.B = '0; bc.opcode = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", {27'd0, bm.out_valid, bm.Y, bm.co, bm.ov, bm.zero},
            {27'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", {31'd0, bm.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Overflowing add and the two subtraction cases, exact latency checked.
        lat_chk = 1'b1;
        send(3'd0, 16'h7FFF, 16'h0001);
        send(3'd1, 16'd5, 16'd7);
        send(3'd1, 16'd9, 16'd9);
        drain();
        for (int i = 0; i < 8; i++) send(t_op[i], t_a[i], t_b[i]);
        drain();

        // Back-to-back stream of adds.
        for (int i = 0; i < 8; i++) send(3'd0, 16'(i * 1000 - 3000), 16'(i * 77));
        drain();

        // Backpressure: two beats fill the pipe, then out_ready stays low.
        lat_chk = 1'b0;
        bm.out_ready = 1'b0;
        send(3'd0, 16'd100, 16'd23);
        send(3'd4, 16'h5A5A, 16'h0FF0);
        @(negedge clk);
        chk("in_ready_full", {31'd0, bm.in_ready}, 32'd0);
        chk("out_valid_full", {31'd0, bm.out_valid}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        bm.out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_full_drain", {31'd0, bm.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        send(3'd1, 16'h8000, 16'h7FFF);
        send(3'd6, 16'hC001, 16'h0000);
        drain();

        // Reset with two beats in flight.
        send(3'd0, 16'd1, 16'd2);
        send(3'd0, 16'd3, 16'd4);
        rst = 1'b1;
        #1;
        chk("rst_async_out_valid", {31'd0, bm.out_valid}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_post_rst", {31'd0, bm.in_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("no_stale_beat", {31'd0, bm.out_valid}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        // Saturating instance.
        sat_case("sat_pos", 3'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0);
        sat_case("sat_neg", 3'd0, 16'h8000, 16'hFFFF, 16'h8000, 1'b1);
        sat_case("sat_sub", 3'd1, 16'h8000, 16'h0001, 16'h8000, 1'b1);

        // Combinational instance.
        bc.in_valid = 1'b1;
        bc.opcode   = 3'd6;
        bc.A        = 16'hFFFF;
        #1;
        chk("comb_shl", {12'd0, bc.out_valid, bc.in_ready, bc.Y, bc.co, bc.ov},
            {12'd0, 1'b1, 1'b1, 16'hFFFE, 1'b1, 1'b0});
        bc.opcode = 3'd7;
        bc.A      = 16'h8001;
        #1;
        chk("comb_shr", {14'd0, bc.Y, bc.co, bc.ov}, {14'd0, 16'hC000, 1'b1, 1'b0});
        bc.out_ready = 1'b0;
        #1;
        chk("comb_in_ready", {31'd0, bc.in_ready}, 32'd0);
        bc.out_ready = 1'b1;
        for (int op = 0; op < 8; op++) begin
            for (int k = 0; k < 3; k++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                bc.opcode = 3'(op);
                bc.A      = ra;
                bc.B      = rb;
                #1;
                r = model(3'(op), ra, rb, 1'b0);
                chk("comb_alu", {13'd0, bc.Y, bc.co, bc.ov, bc.zero}, {13'd0, r});
            end
        end
        bc.in_valid = 1'b0;

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
